// File: rtl/alu_arbiter_pkg.sv
// Shared constants, opcodes and FSM state type for the ALU arbiter slice.
package alu_arbiter_pkg;

    localparam int WORD      = 32;
    localparam int OP_W      = 3;
    localparam int ARB_CNT_W = 16;

    localparam logic [OP_W-1:0] OP_SUM = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_AND = 3'd2;
    localparam logic [OP_W-1:0] OP_OR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bundle of the ALU arbiter: request handshake, response handshake, status.
interface alu_arbiter_if #(
    parameter int WIDTH    = alu_arbiter_pkg::WORD,
    parameter int OP_WIDTH = alu_arbiter_pkg::OP_W,
    parameter int NREQ     = 4,
    parameter int IDW      = $clog2(NREQ)
) ();
    logic [NREQ-1:0]          i_req_valid;
    logic [NREQ-1:0]          o_req_ready;
    logic [NREQ*WIDTH-1:0]    i_req_a;
    logic [NREQ*WIDTH-1:0]    i_req_b;
    logic [NREQ*OP_WIDTH-1:0] i_req_op;
    logic [NREQ-1:0]          o_rsp_valid;
    logic [NREQ-1:0]          i_rsp_ready;
    logic [WIDTH-1:0]         o_rsp_result;
    logic                     o_rsp_zero;
    logic                     o_rsp_cf;
    logic [IDW-1:0]           o_grant_id;
    logic                     o_busy;
    logic [15:0]              o_op_count;

    modport master (
        output i_req_valid, i_req_a, i_req_b, i_req_op, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_result, o_rsp_zero, o_rsp_cf,
               o_grant_id, o_busy, o_op_count
    );

    modport slave (
        input  i_req_valid, i_req_a, i_req_b, i_req_op, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_result, o_rsp_zero, o_rsp_cf,
               o_grant_id, o_busy, o_op_count
    );
endinterface

// File: rtl/alu.sv
// Shared combinational ALU; undecoded opcodes yield zero with no carry.
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH    = WORD,
    parameter int OP_WIDTH = OP_W
) (
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [OP_WIDTH-1:0] op,
    output logic [WIDTH-1:0]    result,
    output logic                zero,
    output logic                cf
);
    logic [WIDTH:0] wide;

    always_comb begin
        wide = '0;
        case (op)
            OP_SUM:  wide = {1'b0, a} + {1'b0, b};
            // cf reports a borrow on subtraction
            OP_SUB:  wide = {1'b0, a} - {1'b0, b};
            OP_AND:  wide = {1'b0, a & b};
            OP_OR:   wide = {1'b0, a | b};
            OP_XOR:  wide = {1'b0, a ^ b};
            default: wide = '0;
        endcase
    end

    assign result = wide[WIDTH-1:0];
    assign cf     = wide[WIDTH];
    assign zero   = (wide[WIDTH-1:0] == '0);
endmodule

// File: rtl/alu_arbiter_rr_pick.sv
// Round-robin picker: first valid requester searching upward from last+1 with wrap.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  sel,
    output logic            any
);
    int idx;

    always_comb begin
        grant = '0;
        sel   = '0;
        any   = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!any && valid[idx]) begin
                any        = 1'b1;
                sel        = IDW'(idx);
                grant[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NREQ requesters: round-robin grant, execute, hold result until accepted.
// state  | meaning
// S_IDLE | picking a requester, ready offered to the winner only
// S_EXEC | ALU driven from operand regs, result captured at the edge
// S_RESP | result held for the owner until its rsp_ready
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH    = WORD,
    parameter int OP_WIDTH = OP_W,
    parameter int NREQ     = 4,
    parameter int IDW      = $clog2(NREQ)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    alu_arbiter_if.slave bus
);
    arb_state_t             state, state_nxt;
    logic [IDW-1:0]         last, sel, grant_id;
    logic [NREQ-1:0]        pick_grant, req_ready, rsp_valid;
    logic                   pick_any, rsp_fire;
    logic [WIDTH-1:0]       a_q, b_q, result_q, alu_result;
    logic [OP_WIDTH-1:0]    op_q;
    logic                   zero_q, cf_q, alu_zero, alu_cf;
    logic [ARB_CNT_W-1:0]   op_count;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .valid (bus.i_req_valid),
        .last  (last),
        .grant (pick_grant),
        .sel   (sel),
        .any   (pick_any)
    );

    alu #(.WIDTH(WIDTH), .OP_WIDTH(OP_WIDTH)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result),
        .zero   (alu_zero),
        .cf     (alu_cf)
    );

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        rsp_fire  = 1'b0;
        case (state)
            S_IDLE: begin
                // ready is withheld during reset so no requester sees a phantom accept
                if (pick_any && !i_rst) begin
                    req_ready = pick_grant;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: state_nxt = S_RESP;
            S_RESP: begin
                rsp_valid[grant_id] = 1'b1;
                if (bus.i_rsp_ready[grant_id]) begin
                    rsp_fire  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            last     <= IDW'(NREQ - 1);
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            grant_id <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            cf_q     <= 1'b0;
            op_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && pick_any) begin
                a_q      <= bus.i_req_a[int'(sel)*WIDTH +: WIDTH];
                b_q      <= bus.i_req_b[int'(sel)*WIDTH +: WIDTH];
                op_q     <= bus.i_req_op[int'(sel)*OP_WIDTH +: OP_WIDTH];
                grant_id <= sel;
            end
            if (state == S_EXEC) begin
                result_q <= alu_result;
                zero_q   <= alu_zero;
                cf_q     <= alu_cf;
            end
            if (rsp_fire) begin
                last     <= grant_id;
                op_count <= op_count + 1'b1;
            end
        end
    end

    assign bus.o_req_ready  = req_ready;
    assign bus.o_rsp_valid  = rsp_valid;
    assign bus.o_rsp_result = result_q;
    assign bus.o_rsp_zero   = zero_q;
    assign bus.o_rsp_cf     = cf_q;
    assign bus.o_grant_id   = grant_id;
    assign bus.o_busy       = (state != S_IDLE);
    assign bus.o_op_count   = op_count;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] res;
        logic        zero;
        logic        cf;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        zero;
        logic        cf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    exp_t e;
    logic [3:0] hs;
    vec_t vecs[8];

    alu_arbiter_if #(.WIDTH(32), .OP_WIDTH(3), .NREQ(4)) bus ();

    alu_arbiter #(.WIDTH(32), .OP_WIDTH(3), .NREQ(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int id, logic [31:0] a, logic [31:0] b, logic [2:0] op);
        bus.i_req_valid[id]     = 1'b1;
        bus.i_req_a[id*32 +: 32] = a;
        bus.i_req_b[id*32 +: 32] = b;
        bus.i_req_op[id*3 +: 3]  = op;
    endtask

    task automatic push(int id, logic [31:0] res, logic zero, logic cf);
        exp_t x;
        x.id = id; x.res = res; x.zero = zero; x.cf = cf;
        exp_q.push_back(x);
    endtask

    task automatic wait_idle(string name, int budget);
        bit done = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!bus.o_busy && exp_q.size() == 0) begin
                done = 1;
                break;
            end
        end
        check(name, 64'(done), 64'd1);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_req_ready"}, 64'(bus.o_req_ready), 64'd0);
        check({tag, "_rsp_valid"}, 64'(bus.o_rsp_valid), 64'd0);
        check({tag, "_busy"},      64'(bus.o_busy), 64'd0);
        check({tag, "_grant_id"},  64'(bus.o_grant_id), 64'd0);
        check({tag, "_op_count"},  64'(bus.o_op_count), 64'd0);
        check({tag, "_result"},    64'(bus.o_rsp_result), 64'd0);
        check({tag, "_zero"},      64'(bus.o_rsp_zero), 64'd0);
        check({tag, "_cf"},        64'(bus.o_rsp_cf), 64'd0);
    endtask

    // Response scoreboard: every response handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (!$onehot0(bus.o_req_ready))
                check("req_ready_onehot0", 64'(bus.o_req_ready), 64'd0);
            hs = bus.o_rsp_valid & bus.i_rsp_ready;
            if (bus.o_rsp_valid != 4'd0 && exp_q.size() == 0) begin
                check("rsp_unexpected", 64'(bus.o_rsp_valid), 64'd0);
            end else if (hs != 4'd0) begin
                e = exp_q.pop_front();
                check("rsp_valid_owner", 64'(bus.o_rsp_valid), 64'(4'b0001 << e.id));
                check("rsp_grant_id",    64'(bus.o_grant_id), 64'(e.id));
                check("rsp_result",      64'(bus.o_rsp_result), 64'(e.res));
                check("rsp_zero",        64'(bus.o_rsp_zero), 64'(e.zero));
                check("rsp_cf",          64'(bus.o_rsp_cf), 64'(e.cf));
            end
        end
    end

    initial begin
        bit done;
        vecs[0] = '{0, 32'd3,          32'd4,          OP_SUM, 32'd7,          1'b0, 1'b0};
        vecs[1] = '{2, 32'hFFFF_FFFF,  32'd1,          OP_SUM, 32'd0,          1'b1, 1'b1};
        vecs[2] = '{1, 32'd5,          32'd3,          OP_SUB, 32'd2,          1'b0, 1'b0};
        vecs[3] = '{3, 32'd3,          32'd5,          OP_SUB, 32'hFFFF_FFFE,  1'b0, 1'b1};
        vecs[4] = '{0, 32'h0000_F0F0,  32'h0000_0FF0,  OP_AND, 32'h0000_00F0,  1'b0, 1'b0};
        vecs[5] = '{2, 32'h0000_F0F0,  32'h0000_0F0F,  OP_OR,  32'h0000_FFFF,  1'b0, 1'b0};
        vecs[6] = '{3, 32'h0000_AAAA,  32'h0000_AAAA,  OP_XOR, 32'd0,          1'b1, 1'b0};
        vecs[7] = '{1, 32'd7,          32'd7,          3'd7,   32'd0,          1'b1, 1'b0};

        bus.i_req_valid = '0;
        bus.i_req_a     = '0;
        bus.i_req_b     = '0;
        bus.i_req_op    = '0;
        bus.i_rsp_ready = '0;
        rst = 1'b1;
        repeat (2) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        bus.i_rsp_ready = 4'hF;
        tick();

        // Single requests with immediate response accept: ready, latency and return to idle.
        for (int i = 0; i < 8; i++) begin
            set_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op);
            push(vecs[i].id, vecs[i].res, vecs[i].zero, vecs[i].cf);
            #1;
            check("vec_req_ready", 64'(bus.o_req_ready), 64'(4'b0001 << vecs[i].id));
            tick();
            bus.i_req_valid = '0;
            check("vec_exec_busy", 64'(bus.o_busy), 64'd1);
            check("vec_exec_no_rsp", 64'(bus.o_rsp_valid), 64'd0);
            tick();
            check("vec_rsp_valid", 64'(bus.o_rsp_valid), 64'(4'b0001 << vecs[i].id));
            tick();
            check("vec_back_idle", 64'(bus.o_busy), 64'd0);
            check("vec_op_count", 64'(bus.o_op_count), 64'(i + 1));
        end
        check("vec_queue_drained", 64'(exp_q.size()), 64'd0);

        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Round-robin with all requesters continuously valid.
        for (int id = 0; id < 4; id++) set_req(id, 32'd5, 32'd3, OP_SUB);
        push(0, 32'd2, 1'b0, 1'b0);
        push(1, 32'd2, 1'b0, 1'b0);
        push(2, 32'd2, 1'b0, 1'b0);
        push(3, 32'd2, 1'b0, 1'b0);
        push(0, 32'd2, 1'b0, 1'b0);
        done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (exp_q.size() == 0) begin
                done = 1;
                break;
            end
        end
        bus.i_req_valid = '0;
        check("rr_five_served", 64'(done), 64'd1);
        wait_idle("rr_idle", 10);

        // Response backpressure from requester 1 while requester 0 waits.
        bus.i_rsp_ready = 4'b1101;
        set_req(1, 32'd3, 32'd5, OP_SUB);
        push(1, 32'hFFFF_FFFE, 1'b0, 1'b1);
        #1;
        check("bp_ready1", 64'(bus.o_req_ready), 64'b0010);
        tick();
        bus.i_req_valid = '0;
        set_req(0, 32'd1, 32'd1, OP_SUM);
        push(0, 32'd2, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_held",  64'(bus.o_rsp_valid), 64'b0010);
            check("bp_result",    64'(bus.o_rsp_result), 64'hFFFF_FFFE);
            check("bp_cf",        64'(bus.o_rsp_cf), 64'd1);
            check("bp_no_ready",  64'(bus.o_req_ready), 64'd0);
            tick();
        end
        bus.i_rsp_ready = 4'hF;
        tick();
        check("bp_done_idle", 64'(bus.o_busy), 64'd0);
        check("bp_next_ready0", 64'(bus.o_req_ready), 64'b0001);
        tick();
        bus.i_req_valid = '0;
        wait_idle("bp_idle", 10);

        // Reset while requester 3 is in EXEC drops its operation.
        set_req(3, 32'd5, 32'd6, OP_XOR);
        #1;
        check("rst_ready3", 64'(bus.o_req_ready), 64'b1000);
        tick();
        check("rst_in_exec", 64'(bus.o_busy), 64'd1);
        rst = 1'b1;
        bus.i_req_valid = '0;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        set_req(0, 32'd2, 32'd3, OP_SUM);
        set_req(3, 32'd5, 32'd6, OP_XOR);
        push(0, 32'd5, 1'b0, 1'b0);
        push(3, 32'd3, 1'b0, 1'b0);
        #1;
        check("rst_after_ready0", 64'(bus.o_req_ready), 64'b0001);
        done = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.o_busy && bus.o_grant_id == 2'd0) bus.i_req_valid[0] = 1'b0;
            if (bus.o_busy && bus.o_grant_id == 2'd3) bus.i_req_valid[3] = 1'b0;
            if (!bus.o_busy && exp_q.size() == 0 && bus.i_req_valid == 4'd0) begin
                done = 1;
                break;
            end
        end
        check("rst_seq_done", 64'(done), 64'd1);
        check("rst_seq_count", 64'(bus.o_op_count), 64'd2);

        // Counter wrap from a preloaded all-ones count.
        force dut.op_count = 16'hFFFF;
        tick();
        release dut.op_count;
        check("wrap_preload", 64'(bus.o_op_count), 64'hFFFF);
        set_req(2, 32'd1, 32'd2, OP_SUM);
        push(2, 32'd3, 1'b0, 1'b0);
        tick();
        bus.i_req_valid = '0;
        wait_idle("wrap_idle", 10);
        check("wrap_count", 64'(bus.o_op_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` among `NREQ` independent requesters, such as a core's execute stage, an address generator and a debug port. Each requester presents operands and an opcode with a valid/ready handshake. The block grants one request at a time in round-robin order, executes it on an internal `alu` instance, and holds the registered result until the owning requester accepts it. It sits between the requesters and the ALU; nothing else drives the ALU.

## Interface
Parameters:
- `WIDTH`, default `` `WORD ``: operand and result width.
- `OP_WIDTH`, default `` `OP_WIDTH ``: opcode width.
- `NREQ`, default 4: number of requesters. Legal range is 2..8.
- `IDW`, default `$clog2(NREQ)`: requester-ID width.

Ports:
- `i_clk`  in  1  clock. Single clock domain; all state changes on the rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_req_valid`  in  NREQ  per-requester request valid.
- `o_req_ready`  out  NREQ  per-requester accept. At most one bit is set.
- `i_req_a`  in  NREQ*WIDTH  operand A; requester i occupies slice [i*WIDTH +: WIDTH].
- `i_req_b`  in  NREQ*WIDTH  operand B, same slicing.
- `i_req_op`  in  NREQ*OP_WIDTH  opcode, same slicing.
- `o_rsp_valid`  out  NREQ  result valid for the owning requester only (one-hot or zero).
- `i_rsp_ready`  in  NREQ  per-requester result accept.
- `o_rsp_result`  out  WIDTH  registered ALU result.
- `o_rsp_zero`  out  1  registered ALU zero flag.
- `o_rsp_cf`  out  1  registered ALU carry flag.
- `o_grant_id`  out  IDW  ID of the in-flight or last-served requester.
- `o_busy`  out  1  high whenever state != IDLE.
- `o_op_count`  out  16  completed operations; wraps at 16'hFFFF to 0.

## Operation
State machine: IDLE -> EXEC -> RESP -> IDLE.

IDLE
- Round-robin picker selects the first requester with `i_req_valid` set, searching from `last+1` upward with wrap-around.
- `o_req_ready[sel]` = 1 combinationally, only in IDLE and only for `sel`.
- On valid & ready: latch a, b, op and `sel` into operand regs and `o_grant_id`, then go to EXEC.
- With no valid requests, stay in IDLE.

EXEC
- The internal `alu` is driven from the operand regs.
- Capture result, zero and cf into the response regs.
- Go to RESP.

RESP
- `o_rsp_valid[o_grant_id]` = 1, held with stable data until `i_rsp_ready[o_grant_id]` is seen.
- On that handshake: `last <= o_grant_id`, `o_op_count` += 1, go to IDLE.
- `i_rsp_ready` bits of other requesters are ignored.

Rules
- Requesters must hold valid and payload stable until ready. Ready depends combinationally on valid; valid must never depend on ready.
- A request whose valid drops before grant is simply not served. No error is raised.
- Opcodes outside the `alu` decode pass through unchanged. The result is whatever `alu` produces.
- Reset values:
  - state = IDLE
  - `last` = NREQ-1, so requester 0 wins first
  - operand regs, `o_rsp_result`, `o_rsp_zero`, `o_rsp_cf`, `o_grant_id`, `o_op_count` = 0
  - `o_req_ready` = 0, `o_rsp_valid` = 0, `o_busy` = 0
- Reset asserted in EXEC or RESP drops the in-flight op. No response is issued, and the cycle after the reset edge shows all outputs at reset values.

## Timing
- Request accepted at edge k. `o_rsp_valid` is high from edge k+2.
- With `i_rsp_ready` already high, the block is back in IDLE at edge k+3 and can accept again in that cycle.
- Peak throughput is one op per 3 cycles. There is no back-to-back overlap.
- `o_req_ready` is 0 throughout EXEC and RESP, even for new requests.
- Fairness: with all NREQ requesters continuously valid, grants cycle 0,1,...,NREQ-1,0,... Worst-case wait is (NREQ-1) operations plus their response stalls.
- Simultaneous events:
  - A new valid during RESP is sampled only after the return to IDLE.
  - A requester whose response is being accepted may have its next request granted in the following IDLE cycle only if no higher round-robin candidate is valid.

## Structure
- Shared constants go in `specs.vh`:
  - `` `ARB_S_IDLE `` = 2'd0, `` `ARB_S_EXEC `` = 2'd1, `` `ARB_S_RESP `` = 2'd2
  - `` `ARB_CNT_W `` = 16
  - Existing `` `WORD ``, `` `OP_WIDTH `` and `` `OP_* `` are reused.
- Sub-modules:
  - `rr_pick`: combinational. Inputs are `NREQ` valid bits and `last`. Outputs are one-hot grant, encoded `sel` and `any`.
  - Existing `alu`: one internal instance.
- The top level holds the FSM, operand regs, response regs and counter.

## Test plan
- **Single request:** req0 a=3, b=4, op=`` `OP_SUM ``, rsp_ready=1 -> ready0 at cycle 0; rsp_valid0 at edge+2 with result=7, cf=0, zero=0; `o_op_count`=1.
- **Carry and zero:** req2 a=32'hFFFFFFFF, b=1, `` `OP_SUM `` -> result=0, cf=1, zero=1, `o_grant_id`=2, only `o_rsp_valid[2]` set.
- **Round-robin:** req0..3 all valid continuously with `` `OP_SUB `` a=5, b=3 -> grant order 0,1,2,3,0; every result=2; no requester served twice in a row.
- **Response backpressure:** req1 a=3, b=5, `` `OP_SUB ``, `i_rsp_ready`=0 for 5 cycles -> result=32'hFFFFFFFE, cf=1 held stable; `o_req_ready`=0 all along, even with req0 valid; completes 1 cycle after `i_rsp_ready[1]` rises.
- **Reset mid-operation:** assert `i_rst` during EXEC of req3 (`` `OP_XOR ``) -> no `o_rsp_valid`; next cycle all outputs at reset values; the following request from req0 and req3 grants req0 first.
- **Counter wrap:** preload by running 65536 ops (or force `o_op_count`=16'hFFFF) -> one more completed op gives 0.
